// File: rtl/cgra_pe_if.sv
// Bundle of the PE's configuration word, neighbour/LSU inputs and outputs.
// The master side (array fabric or bench) drives inst/din; the PE drives dout.
interface cgra_pe_if;
  logic [47:0] inst;
  logic [31:0] din_N, din_S, din_W, din_E, din_LSU;
  logic [31:0] dout_N, dout_S, dout_W, dout_E, dout_LSU;

  modport master (
    output inst, din_N, din_S, din_W, din_E, din_LSU,
    input  dout_N, dout_S, dout_W, dout_E, dout_LSU
  );
  modport slave (
    input  inst, din_N, din_S, din_W, din_E, din_LSU,
    output dout_N, dout_S, dout_W, dout_E, dout_LSU
  );
endinterface

// File: rtl/cgra_pe.sv
// CGRA processing element: 5x4 crossbar into a 4-entry register file,
// 9x7 crossbar for ALU operands and outputs, registered ALU result RES.
module cgra_pe (
  input  logic      clk,
  input  logic      rst,
  cgra_pe_if.slave  pe_if
);
  logic [31:0] r_rf [4];
  logic [31:0] r_res;
  logic [31:0] w_src9 [16];
  logic [31:0] w_src5 [8];
  logic [31:0] w_out  [7];
  logic [31:0] w_a, w_b, w_alu;
  logic [3:0]  w_op;

  assign w_op = pe_if.inst[47:44];

  // Source tables padded to a power of two so unused select codes read 0.
  always_comb begin
    for (int k = 0; k < 16; k++) w_src9[k] = '0;
    w_src9[0] = pe_if.din_N;
    w_src9[1] = pe_if.din_S;
    w_src9[2] = pe_if.din_W;
    w_src9[3] = pe_if.din_E;
    for (int k = 0; k < 4; k++) w_src9[4+k] = r_rf[k];
    w_src9[8] = r_res;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) w_src5[k] = '0;
    w_src5[0] = pe_if.din_N;
    w_src5[1] = pe_if.din_S;
    w_src5[2] = pe_if.din_W;
    w_src5[3] = pe_if.din_E;
    w_src5[4] = pe_if.din_LSU;
  end

  // Output order from the MSB of the 9x7 field: LSU, opA, opB, N, S, W, E.
  always_comb begin
    for (int k = 0; k < 7; k++) w_out[k] = w_src9[pe_if.inst[43-4*k -: 4]];
  end

  assign w_a            = w_out[1];
  assign w_b            = w_out[2];
  assign pe_if.dout_LSU = w_out[0];
  assign pe_if.dout_N   = w_out[3];
  assign pe_if.dout_S   = w_out[4];
  assign pe_if.dout_W   = w_out[5];
  assign pe_if.dout_E   = w_out[6];

  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd0:  w_alu = w_a + w_b;
      4'd1:  w_alu = w_a - w_b;
      4'd2:  w_alu = w_a * w_b;
      4'd3:  w_alu = w_a & w_b;
      4'd4:  w_alu = w_a | w_b;
      4'd5:  w_alu = w_a ^ w_b;
      4'd6:  w_alu = w_a << w_b[4:0];
      4'd7:  w_alu = w_a >> w_b[4:0];
      4'd8:  w_alu = $signed(w_a) >>> w_b[4:0];
      4'd9:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      4'd10: w_alu = {31'd0, w_a < w_b};
      4'd11: w_alu = {31'd0, w_a == w_b};
      4'd12: w_alu = w_a;
      4'd13: w_alu = w_b;
      4'd14: w_alu = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
      4'd15: w_alu = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
      default: w_alu = '0;
    endcase
  end

  // reg_file_sel bit3 enables R0 down to bit0 for R3; selects run R0..R3 from MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) r_rf[k] <= '0;
      r_res <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (pe_if.inst[3-k]) r_rf[k] <= w_src5[pe_if.inst[15-3*k -: 3]];
      r_res <= w_alu;
    end
  end
endmodule

// File: tb/tb_cgra_pe.sv
// Self-checking bench for cgra_pe: directed sequences, an opcode table and
// randomized configurations against an array-based reference model.
module tb_cgra_pe;
  logic clk = 1'b0;
  logic rst;
  cgra_pe_if bus ();

  cgra_pe dut (.clk(clk), .rst(rst), .pe_if(bus.slave));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mR [4];
  logic [31:0] mRes;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [17];

  localparam logic [47:0] REF_INST = 48'h07074807883f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] mk_inst(
    input logic [3:0] op, lsu, a, b, n, s, w, e,
    input logic [2:0] r0, r1, r2, r3, input logic [3:0] sel);
    return {op, lsu, a, b, n, s, w, e, r0, r1, r2, r3, sel};
  endfunction

  function automatic logic [31:0] src9(input logic [3:0] s);
    if (s == 0) return bus.din_N;
    if (s == 1) return bus.din_S;
    if (s == 2) return bus.din_W;
    if (s == 3) return bus.din_E;
    if (s >= 4 && s <= 7) return mR[s-4];
    if (s == 8) return mRes;
    return 32'd0;
  endfunction

  function automatic logic [31:0] src5(input logic [2:0] s);
    logic [31:0] d [5];
    d = '{bus.din_N, bus.din_S, bus.din_W, bus.din_E, bus.din_LSU};
    return (s < 5) ? d[s] : 32'd0;
  endfunction

  function automatic logic [31:0] alu_m(input logic [3:0] op, input logic [31:0] a, b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return 32'(sa * sb);
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a << b[4:0];
      7:  return a >> b[4:0];
      8:  return 32'(sa >>> b[4:0]);
      9:  return (sa < sb) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      11: return (a == b) ? 32'd1 : 32'd0;
      12: return a;
      13: return b;
      14: return (sa < sb) ? a : b;
      default: return (sa > sb) ? a : b;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) mR[k] = '0;
    mRes = '0;
  endtask

  // Compute next state from the current inputs, then take one clock edge.
  task automatic step();
    logic [31:0] nR [4];
    logic [31:0] nres;
    for (int k = 0; k < 4; k++)
      nR[k] = bus.inst[3-k] ? src5(bus.inst[15-3*k -: 3]) : mR[k];
    nres = alu_m(bus.inst[47:44], src9(bus.inst[39:36]), src9(bus.inst[35:32]));
    @(posedge clk);
    if (rst) begin
      mR   = nR;
      mRes = nres;
    end
    #1;
  endtask

  task automatic check_outs(input string p);
    chk({p, "_LSU"}, bus.dout_LSU, src9(bus.inst[43:40]));
    chk({p, "_N"},   bus.dout_N,   src9(bus.inst[31:28]));
    chk({p, "_S"},   bus.dout_S,   src9(bus.inst[27:24]));
    chk({p, "_W"},   bus.dout_W,   src9(bus.inst[23:20]));
    chk({p, "_E"},   bus.dout_E,   src9(bus.inst[19:16]));
  endtask

  task automatic set_din(input logic [31:0] n, s, w, e, l);
    bus.din_N = n; bus.din_S = s; bus.din_W = w; bus.din_E = e; bus.din_LSU = l;
  endtask

  initial begin
    tbl[0]  = '{"add",  4'd0,  32'd5, -32'sd3, 32'd2};
    tbl[1]  = '{"sub",  4'd1,  32'd5, -32'sd3, 32'd8};
    tbl[2]  = '{"mul",  4'd2,  32'd5, -32'sd3, -32'sd15};
    tbl[3]  = '{"and",  4'd3,  32'd5, -32'sd3, 32'h0000_0005};
    tbl[4]  = '{"or",   4'd4,  32'd5, -32'sd3, 32'hffff_fffd};
    tbl[5]  = '{"xor",  4'd5,  32'd5, -32'sd3, 32'hffff_fff8};
    tbl[6]  = '{"sll",  4'd6,  32'd5, -32'sd3, 32'ha000_0000};
    tbl[7]  = '{"srl",  4'd7,  32'd5, -32'sd3, 32'd0};
    tbl[8]  = '{"sra",  4'd8,  -32'sd3, 32'd5, 32'hffff_ffff};
    tbl[9]  = '{"slt",  4'd9,  32'd5, -32'sd3, 32'd0};
    tbl[10] = '{"sltu", 4'd10, 32'd5, -32'sd3, 32'd1};
    tbl[11] = '{"eq",   4'd11, 32'd5, -32'sd3, 32'd0};
    tbl[12] = '{"pasA", 4'd12, 32'd5, -32'sd3, 32'd5};
    tbl[13] = '{"pasB", 4'd13, 32'd5, -32'sd3, 32'hffff_fffd};
    tbl[14] = '{"min",  4'd14, 32'd5, -32'sd3, 32'hffff_fffd};
    tbl[15] = '{"max",  4'd15, 32'd5, -32'sd3, 32'd5};
    tbl[16] = '{"eq1",  4'd11, 32'd7, 32'd7,   32'd1};

    // Reset state with the reference config applied
    rst = 1'b0;
    model_clear();
    bus.inst = REF_INST;
    set_din(5, 6, 7, 8, 9);
    #1;
    chk("rst_N", bus.dout_N, 32'd0);
    chk("rst_S", bus.dout_S, 32'd0);
    chk("rst_W", bus.dout_W, 32'd5);
    chk("rst_LSU", bus.dout_LSU, 32'd0);
    #2 rst = 1'b1;

    // Reference config: two edges
    step();
    chk("ref1_N", bus.dout_N, 32'd9);
    chk("ref1_LSU", bus.dout_LSU, 32'd8);
    chk("ref1_E", bus.dout_E, 32'd8);
    chk("ref1_W", bus.dout_W, 32'd5);
    check_outs("ref1");
    step();
    chk("ref2_S", bus.dout_S, 32'd13);

    // Reset mid-run while RES=13
    #2 rst = 1'b0;
    model_clear();
    #1;
    chk("mrst_S", bus.dout_S, 32'd0);
    chk("mrst_N", bus.dout_N, 32'd0);
    chk("mrst_W", bus.dout_W, 32'd5);
    rst = 1'b1;
    step();
    check_outs("rel");

    // Hold: R0..R3 = 9,7,5,8 must persist with reg_file_sel=0
    bus.inst = mk_inst(0, 8, 0, 0, 4, 5, 6, 7, 4, 2, 0, 3, 4'h0);
    for (int i = 0; i < 3; i++) begin
      set_din($urandom, $urandom, $urandom, $urandom, $urandom);
      step();
      chk("hold_R0", bus.dout_N, 32'd9);
      chk("hold_R1", bus.dout_S, 32'd7);
      chk("hold_R2", bus.dout_W, 32'd5);
      chk("hold_R3", bus.dout_E, 32'd8);
    end

    // Opcode sweep: A=din_N, B=din_E, result via RES on dout_S
    foreach (tbl[i]) begin
      bus.inst = mk_inst(tbl[i].op, 8, 0, 3, 4, 8, 5, 6, 0, 0, 0, 0, 4'h0);
      set_din(tbl[i].a, 32'h1111, 32'h2222, tbl[i].b, 32'h3333);
      step();
      chk({"op_", tbl[i].nm}, bus.dout_S, tbl[i].exp);
    end

    // Invalid selects: 9x7 code 12 on N, 5x4 code 6 into R0
    bus.inst = mk_inst(0, 8, 0, 3, 12, 4, 5, 6, 6, 0, 0, 0, 4'b1000);
    set_din(32'hdead_beef, 1, 2, 3, 4);
    #1;
    chk("inv9_N", bus.dout_N, 32'd0);
    chk("inv_pre_R0", bus.dout_S, 32'd9);
    step();
    chk("inv5_R0", bus.dout_S, 32'd0);
    chk("inv9_N2", bus.dout_N, 32'd0);

    // Feedback accumulate from reset: RES += din_N each cycle
    #2 rst = 1'b0;
    model_clear();
    bus.inst = mk_inst(0, 8, 8, 0, 8, 8, 8, 8, 0, 0, 0, 0, 4'h0);
    set_din(1, 0, 0, 0, 0);
    #1;
    chk("acc0", bus.dout_S, 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("acc%0d", k), bus.dout_S, 32'(k));
    end

    // Randomized configs against the reference model
    for (int i = 0; i < 300; i++) begin
      bus.inst = {$urandom, $urandom} ;
      if ($urandom_range(0, 3) == 0) bus.inst[43:16] = {7{4'($urandom_range(0, 8))}};
      set_din($urandom, $urandom, $urandom, $urandom, $urandom);
      #1;
      check_outs("rnd");
      step();
      check_outs("rndp");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
